// File: rtl/debug_tx_scheduler.sv
// Round-robin scheduler that frames telemetry records onto the debug UART.
// Frame: sync, {src,len}, payload, running XOR checksum.
module debug_tx_scheduler #(
  parameter int         NUM_SRC     = 4,
  parameter int         MAX_LEN     = 8,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         ACC_TIMEOUT = 16
) (
  input  logic                         clock,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [NUM_SRC-1:0]           src_req,
  input  logic [NUM_SRC*4-1:0]         src_len,
  input  logic [NUM_SRC*MAX_LEN*8-1:0] src_data,
  output logic [NUM_SRC-1:0]           src_ack,
  output logic                         tx_send,
  output logic [7:0]                   tx_byte,
  input  logic                         tx_done,
  output logic                         busy,
  output logic [2:0]                   cur_src,
  output logic [15:0]                  frame_cnt
);

  localparam int TW = $clog2(ACC_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_LOAD,
    S_SEND,
    S_WAIT_ACC,
    S_WAIT_DONE,
    S_FINISH
  } state_t;

  state_t                   state;
  logic [2:0]               rr_ptr;
  logic [MAX_LEN*8-1:0]     data_q;
  logic [3:0]               len_q;
  logic [4:0]               idx;
  logic [7:0]               csum;
  logic [TW-1:0]            tmo;

  logic [2:0]               sel;
  logic                     found;
  int                       j;
  logic [3:0]               raw_len;
  logic [3:0]               clamp_len;
  logic [4:0]               last_idx;
  logic [4:0]               pidx;
  logic [7:0]               byte_nxt;

  // First requester at or after the round-robin pointer.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (!found && src_req[j]) begin
        found = 1'b1;
        sel   = 3'(j);
      end
    end
  end

  assign raw_len   = src_len[sel*4 +: 4];
  assign clamp_len = (raw_len > 4'(MAX_LEN)) ? 4'(MAX_LEN) : raw_len;
  assign last_idx  = {1'b0, len_q} + 5'd2;
  assign pidx      = idx - 5'd2;

  always_comb begin
    byte_nxt = '0;
    unique case (1'b1)
      idx == 5'd0:     byte_nxt = SYNC_BYTE;
      idx == 5'd1:     byte_nxt = {1'b0, cur_src, len_q};
      idx == last_idx: byte_nxt = csum;
      default:         byte_nxt = data_q[pidx*8 +: 8];
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      data_q    <= '0;
      len_q     <= '0;
      idx       <= '0;
      csum      <= '0;
      tmo       <= '0;
      src_ack   <= '0;
      tx_send   <= 1'b0;
      tx_byte   <= '0;
      busy      <= 1'b0;
      cur_src   <= '0;
      frame_cnt <= '0;
    end else begin
      src_ack <= '0;
      tx_send <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable && |src_req) state <= S_GRANT;
        end
        S_GRANT: begin
          if (found) begin
            data_q  <= src_data[sel*MAX_LEN*8 +: MAX_LEN*8];
            len_q   <= clamp_len;
            src_ack <= NUM_SRC'(1) << sel;
            cur_src <= sel;
            rr_ptr  <= (sel == 3'(NUM_SRC - 1)) ? 3'd0 : sel + 3'd1;
            busy    <= 1'b1;
            idx     <= '0;
            csum    <= '0;
            state   <= S_LOAD;
          end else begin
            state <= S_IDLE;
          end
        end
        S_LOAD: begin
          tx_byte <= byte_nxt;
          if (tx_done) state <= S_SEND;
        end
        S_SEND: begin
          tx_send <= 1'b1;
          tmo     <= '0;
          state   <= S_WAIT_ACC;
        end
        S_WAIT_ACC: begin
          if (!tx_done) state <= S_WAIT_DONE;
          else if (tmo == TW'(ACC_TIMEOUT - 1)) state <= S_LOAD;
          else tmo <= tmo + 1'b1;
        end
        S_WAIT_DONE: begin
          if (tx_done) begin
            // Header and payload feed the checksum; sync and csum do not.
            if (idx != 5'd0 && idx != last_idx) csum <= csum ^ tx_byte;
            idx <= idx + 5'd1;
            if (idx + 5'd1 == {1'b0, len_q} + 5'd3) state <= S_FINISH;
            else state <= S_LOAD;
          end
        end
        S_FINISH: begin
          frame_cnt <= frame_cnt + 16'd1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_tx_scheduler.sv
// Directed bench for debug_tx_scheduler with a behavioural uart_tx model.
// Vector table for single-source frames, hand sequences for the rest.
module tb_debug_tx_scheduler;

  localparam int NS = 4;
  localparam int ML = 8;

  logic              clock = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic [NS-1:0]     src_req = '0;
  logic [NS*4-1:0]   src_len = '0;
  logic [NS*ML*8-1:0] src_data = '0;
  logic [NS-1:0]     src_ack;
  logic              tx_send;
  logic [7:0]        tx_byte;
  logic              tx_done = 1'b1;
  logic              busy;
  logic [2:0]        cur_src;
  logic [15:0]       frame_cnt;

  always #5 clock = ~clock;

  debug_tx_scheduler dut (
    .clock(clock), .rst_n(rst_n), .enable(enable),
    .src_req(src_req), .src_len(src_len), .src_data(src_data),
    .src_ack(src_ack), .tx_send(tx_send), .tx_byte(tx_byte),
    .tx_done(tx_done), .busy(busy), .cur_src(cur_src),
    .frame_cnt(frame_cnt)
  );

  logic [7:0] got[$];
  int busy_left = 0;
  int ign_target = 0;
  int ign_done = 0;

  // uart_tx: accepts on send while idle, then shifts for 10 cycles
  always @(posedge clock) begin
    if (tx_send && tx_done) begin
      if (ign_done < ign_target) ign_done++;
      else begin
        got.push_back(tx_byte);
        tx_done <= 1'b0;
        busy_left = 10;
      end
    end else if (!tx_done) begin
      busy_left--;
      if (busy_left == 0) tx_done <= 1'b1;
    end
  end

  int ack_cnt = 0;
  int send_cnt = 0;
  int cyc = 0;
  int ack_src[$];
  int send_t[$];

  always @(negedge clock) begin
    cyc++;
    if (src_ack != '0) begin
      ack_cnt++;
      for (int i = 0; i < NS; i++)
        if (src_ack[i]) ack_src.push_back(i);
    end
    if (tx_send) begin
      send_cnt++;
      send_t.push_back(cyc);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic set_byte(input int s, input int k, input logic [7:0] b);
    src_data[(s*ML+k)*8 +: 8] = b;
  endtask

  task automatic set_len(input int s, input logic [3:0] l);
    src_len[s*4 +: 4] = l;
  endtask

  task automatic run_frame(input int s, input bit mangle, output bit ok);
    int k0;
    int f0;
    int w;
    k0 = ack_cnt;
    f0 = int'(frame_cnt);
    ok = 1'b1;
    got.delete();
    src_req = NS'(1 << s);
    w = 0;
    while (ack_cnt == k0 && w < 100) begin tick(); w++; end
    src_req = '0;
    if (ack_cnt == k0) ok = 1'b0;
    if (mangle) begin
      tick();
      set_byte(s, 0, 8'h99);
      set_byte(s, 1, 8'h88);
    end
    w = 0;
    while (int'(frame_cnt) == f0 && w < 3000) begin tick(); w++; end
    if (int'(frame_cnt) == f0) ok = 1'b0;
  endtask

  function automatic logic [31:0] got_at(input int k);
    if (k < got.size()) return 32'(got[k]);
    return 32'hDEAD;
  endfunction

  typedef struct {
    int         sel;
    logic [3:0] len;
    logic [7:0] d[8];
    int         n;
    logic [7:0] e[11];
  } vec_t;

  vec_t v[4];

  initial begin
    bit ok;
    int k0;
    int f0;
    int w;

    v[0] = '{sel: 0, len: 4'd2,
             d: '{8'h12, 8'h34, 0, 0, 0, 0, 0, 0}, n: 5,
             e: '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h24, 0, 0, 0, 0, 0, 0}};
    v[1] = '{sel: 2, len: 4'd0,
             d: '{default: 8'h00}, n: 3,
             e: '{8'hA5, 8'h20, 8'h20, 0, 0, 0, 0, 0, 0, 0, 0}};
    v[2] = '{sel: 1, len: 4'd15,
             d: '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08},
             n: 11,
             e: '{8'hA5, 8'h18, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                  8'h06, 8'h07, 8'h08, 8'h10}};
    v[3] = '{sel: 3, len: 4'd1,
             d: '{8'hFF, 0, 0, 0, 0, 0, 0, 0}, n: 4,
             e: '{8'hA5, 8'h31, 8'hFF, 8'hCE, 0, 0, 0, 0, 0, 0, 0}};

    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_send", 32'(tx_send), 0);
    chk("rst_byte", 32'(tx_byte), 0);
    chk("rst_ack", 32'(src_ack), 0);
    chk("rst_src", 32'(cur_src), 0);
    chk("rst_fcnt", 32'(frame_cnt), 0);
    rst_n = 1'b1;
    enable = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      set_len(v[i].sel, v[i].len);
      for (int k = 0; k < 8; k++) set_byte(v[i].sel, k, v[i].d[k]);
      k0 = ack_cnt;
      f0 = int'(frame_cnt);
      run_frame(v[i].sel, 1'b0, ok);
      chk($sformatf("v%0d_done", i), 32'(ok), 1);
      tick();
      chk($sformatf("v%0d_acks", i), 32'(ack_cnt - k0), 1);
      chk($sformatf("v%0d_fcnt", i), 32'(frame_cnt), 32'(f0 + 1));
      chk($sformatf("v%0d_busy", i), 32'(busy), 0);
      chk($sformatf("v%0d_src", i), 32'(cur_src), 32'(v[i].sel));
      chk($sformatf("v%0d_nbytes", i), 32'(got.size()), 32'(v[i].n));
      for (int k = 0; k < v[i].n; k++)
        chk($sformatf("v%0d_b%0d", i, k), got_at(k), 32'(v[i].e[k]));
    end

    // round robin with all four requesting
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int s = 0; s < NS; s++) begin
      set_len(s, 4'd1);
      set_byte(s, 0, 8'(8'h40 + s));
    end
    got.delete();
    ack_src.delete();
    src_req = 4'b1111;
    w = 0;
    while (ack_src.size() < 5 && w < 1000) begin tick(); w++; end
    src_req = '0;
    w = 0;
    while (frame_cnt != 16'd5 && w < 1000) begin tick(); w++; end
    chk("rr_frames", 32'(frame_cnt), 5);
    for (int f = 0; f < 5; f++) begin
      chk($sformatf("rr_src%0d", f),
          (f < ack_src.size()) ? 32'(ack_src[f]) : 32'hDEAD, 32'(f % 4));
      chk($sformatf("rr_hdr%0d", f), got_at(4*f + 1),
          32'({4'(f % 4), 4'd1}));
    end

    // enable dropped mid-frame: frame finishes, no new grant
    k0 = ack_cnt;
    f0 = int'(frame_cnt);
    src_req = 4'b0001;
    w = 0;
    while (ack_cnt == k0 && w < 100) begin tick(); w++; end
    enable = 1'b0;
    w = 0;
    while (int'(frame_cnt) == f0 && w < 1000) begin tick(); w++; end
    chk("en_fcnt", 32'(frame_cnt), 32'(f0 + 1));
    repeat (30) tick();
    chk("en_acks", 32'(ack_cnt - k0), 1);
    chk("en_busy", 32'(busy), 0);
    src_req = '0;
    enable = 1'b1;

    // snapshot: data changes the cycle after ack
    set_len(0, 4'd2);
    set_byte(0, 0, 8'h12);
    set_byte(0, 1, 8'h34);
    run_frame(0, 1'b1, ok);
    chk("snap_done", 32'(ok), 1);
    chk("snap_p0", got_at(2), 32'h12);
    chk("snap_p1", got_at(3), 32'h34);
    chk("snap_cs", got_at(4), 32'h24);

    // acceptance timeout: uart ignores the first send
    set_byte(0, 0, 8'h12);
    set_byte(0, 1, 8'h34);
    send_t.delete();
    k0 = send_cnt;
    ign_target = ign_done + 1;
    run_frame(0, 1'b0, ok);
    chk("tmo_done", 32'(ok), 1);
    chk("tmo_sends", 32'(send_cnt - k0), 6);
    chk("tmo_gap", (send_t.size() > 1) ? 32'(send_t[1] - send_t[0])
                                       : 32'hDEAD, 18);
    chk("tmo_n", 32'(got.size()), 5);
    chk("tmo_b0", got_at(0), 32'hA5);
    chk("tmo_b1", got_at(1), 32'h02);
    chk("tmo_b4", got_at(4), 32'h24);

    // reset mid-frame, then restart
    got.delete();
    src_req = 4'b0001;
    w = 0;
    while (got.size() < 2 && w < 500) begin tick(); w++; end
    chk("mid_bytes", 32'(got.size()), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(busy), 0);
    chk("mid_send", 32'(tx_send), 0);
    chk("mid_byte", 32'(tx_byte), 0);
    chk("mid_fcnt", 32'(frame_cnt), 0);
    chk("mid_src", 32'(cur_src), 0);
    tick();
    tick();
    rst_n = 1'b1;
    got.delete();
    k0 = ack_cnt;
    w = 0;
    while (ack_cnt == k0 && w < 100) begin tick(); w++; end
    src_req = '0;
    w = 0;
    while (frame_cnt == 16'd0 && w < 1000) begin tick(); w++; end
    chk("rs_fcnt", 32'(frame_cnt), 1);
    chk("rs_n", 32'(got.size()), 5);
    chk("rs_b0", got_at(0), 32'hA5);
    chk("rs_b2", got_at(2), 32'h12);
    chk("rs_b4", got_at(4), 32'h24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
